// File: rtl/unit_gather_net.sv
// rtl/unit_gather_net.sv - round-robin gather of N unit words into a registered root pipeline
module unit_gather_net #(
  parameter int DATA_WIDTH  = 16,
  parameter int N_UNITS     = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [N_UNITS*DATA_WIDTH-1:0] unit_in,
  input  logic [N_UNITS-1:0]            unit_in_valid,
  output logic [N_UNITS-1:0]            unit_in_rd_en,
  output logic [DATA_WIDTH-1:0]         out,
  output logic [3:0]                    out_unit_id,
  output logic                          out_valid,
  input  logic                          out_rd_en
);

  localparam int         PW      = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int         LAST    = PIPE_STAGES - 1;
  localparam logic [3:0] LAST_ID = 4'(N_UNITS - 1);

  (* shreg_extract = "no", equivalent_register_removal = "no" *)
  logic [DATA_WIDTH-1:0]  stg_data [PIPE_STAGES];
  (* shreg_extract = "no", equivalent_register_removal = "no" *)
  logic [3:0]             stg_id   [PIPE_STAGES];
  (* shreg_extract = "no", equivalent_register_removal = "no" *)
  logic [PIPE_STAGES-1:0] stg_valid;
  (* shreg_extract = "no", equivalent_register_removal = "no" *)
  logic [3:0]             ptr;

  logic [PIPE_STAGES-1:0] adv;
  logic [PIPE_STAGES:0]   rdy;
  logic                   found;
  logic                   grant;
  logic [PW-1:0]          gnt_sel;
  logic [3:0]             gnt_id;
  logic [DATA_WIDTH-1:0]  gnt_data;

  // Ready ripples back from the root so a full pipe can shift and refill in one cycle
  always_comb begin
    adv = '0;
    rdy = '0;
    rdy[PIPE_STAGES] = out_rd_en;
    for (int k = LAST; k >= 0; k--) begin
      adv[k] = stg_valid[k] & rdy[k+1];
      rdy[k] = ~stg_valid[k] | adv[k];
    end
  end

  // Round-robin search starting at the pointer, wrapping modulo N_UNITS
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    gnt_sel  = '0;
    gnt_id   = '0;
    gnt_data = '0;
    for (int j = 0; j < N_UNITS; j++) begin
      idx = (int'(ptr) + j) % N_UNITS;
      if (!found && unit_in_valid[idx[PW-1:0]]) begin
        found    = 1'b1;
        gnt_sel  = idx[PW-1:0];
        gnt_id   = idx[3:0];
        gnt_data = unit_in[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grant only when stage 0 can take the word; reset forces the strobe low
  always_comb begin
    grant         = found & rdy[0] & ~reset;
    unit_in_rd_en = '0;
    if (grant) unit_in_rd_en[gnt_sel] = 1'b1;
  end

  // Pointer update and stage shifting with bubble collapse
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      stg_valid <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stg_data[k] <= '0;
        stg_id[k]   <= '0;
      end
    end else begin
      if (grant) ptr <= (gnt_id == LAST_ID) ? 4'd0 : gnt_id + 4'd1;
      if (grant) begin
        stg_data[0]  <= gnt_data;
        stg_id[0]    <= gnt_id;
        stg_valid[0] <= 1'b1;
      end else if (adv[0]) begin
        stg_valid[0] <= 1'b0;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (adv[k-1]) begin
          stg_data[k]  <= stg_data[k-1];
          stg_id[k]    <= stg_id[k-1];
          stg_valid[k] <= 1'b1;
        end else if (adv[k]) begin
          stg_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out         = stg_data[LAST];
  assign out_unit_id = stg_id[LAST];
  assign out_valid   = stg_valid[LAST];

endmodule

// File: tb/tb_unit_gather_net.sv
// tb/tb_unit_gather_net.sv - directed self-checking bench for unit_gather_net
module tb_unit_gather_net;
  localparam int DW = 16;
  localparam int NU = 8;
  localparam int PS = 2;

  logic           clk;
  logic           reset;
  logic [NU*DW-1:0] unit_in;
  logic [NU-1:0]  unit_in_valid;
  logic [NU-1:0]  unit_in_rd_en;
  logic [DW-1:0]  out;
  logic [3:0]     out_unit_id;
  logic           out_valid;
  logic           out_rd_en;

  int n_cmp = 0;
  int n_bad = 0;

  unit_gather_net #(.DATA_WIDTH(DW), .N_UNITS(NU), .PIPE_STAGES(PS)) dut (
    .CLK(clk),
    .reset(reset),
    .unit_in(unit_in),
    .unit_in_valid(unit_in_valid),
    .unit_in_rd_en(unit_in_rd_en),
    .out(out),
    .out_unit_id(out_unit_id),
    .out_valid(out_valid),
    .out_rd_en(out_rd_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    unit_in       = '0;
    unit_in_valid = 8'hFF;
    out_rd_en     = 1'b1;
    for (int i = 0; i < NU; i++) unit_in[i*DW +: DW] = 16'hC0C0 + 16'(i);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_id", 32'(out_unit_id), 32'h0);
    check("rst_rd_en", 32'(unit_in_rd_en), 32'h0);

    // single word from unit 3
    reset = 1'b0;
    unit_in_valid = 8'h00;
    unit_in[3*DW +: DW] = 16'h00A5;
    step();
    unit_in_valid = 8'h08;
    #1;
    check("u3_rd_en", 32'(unit_in_rd_en), 32'h08);
    step();
    unit_in_valid = 8'h00;
    #1;
    check("u3_rd_en_off", 32'(unit_in_rd_en), 32'h00);
    check("u3_lat1_valid", 32'(out_valid), 32'h0);
    step();
    check("u3_out_valid", 32'(out_valid), 32'h1);
    check("u3_out", 32'(out), 32'h00A5);
    check("u3_out_id", 32'(out_unit_id), 32'h3);
    step();
    check("u3_consumed", 32'(out_valid), 32'h0);

    // out_rd_en held high with an empty pipe changes nothing
    step();
    step();
    check("idle_rd_valid", 32'(out_valid), 32'h0);
    check("idle_rd_rd_en", 32'(unit_in_rd_en), 32'h0);
    unit_in[3*DW +: DW] = 16'hC0C3;

    // unit 2 alone from pointer 4 wraps to 2, leaving pointer at 3
    unit_in_valid = 8'h04;
    #1;
    check("wrap_rd_en", 32'(unit_in_rd_en), 32'h04);
    step();
    unit_in_valid = 8'h00;
    step();
    check("wrap_out_id", 32'(out_unit_id), 32'h2);
    check("wrap_out_valid", 32'(out_valid), 32'h1);
    step();
    check("wrap_drained", 32'(out_valid), 32'h0);

    // units 2 and 5 with pointer 3
    unit_in_valid = 8'h24;
    #1;
    check("p3_first", 32'(unit_in_rd_en), 32'h20);
    step();
    unit_in_valid = 8'h04;
    #1;
    check("p3_second", 32'(unit_in_rd_en), 32'h04);
    step();
    unit_in_valid = 8'h18;
    #1;
    check("p3_ptr_back", 32'(unit_in_rd_en), 32'h08);
    check("p3_out5_id", 32'(out_unit_id), 32'h5);
    check("p3_out5_data", 32'(out), 32'hC0C5);
    step();
    unit_in_valid = 8'h10;
    #1;
    check("p3_next4", 32'(unit_in_rd_en), 32'h10);
    check("p3_out2_id", 32'(out_unit_id), 32'h2);
    step();
    unit_in_valid = 8'h00;
    #1;
    check("p3_out3_id", 32'(out_unit_id), 32'h3);
    step();
    check("p3_out4_id", 32'(out_unit_id), 32'h4);
    check("p3_out4_data", 32'(out), 32'hC0C4);
    step();
    check("p3_drained", 32'(out_valid), 32'h0);

    // back-pressure: fill with out_rd_en low, then release
    unit_in_valid = 8'hFF;
    out_rd_en = 1'b0;
    #1;
    check("bp_g1", 32'(unit_in_rd_en), 32'h20);
    step();
    check("bp_g2", 32'(unit_in_rd_en), 32'h40);
    step();
    check("bp_full_rd_en", 32'(unit_in_rd_en), 32'h00);
    check("bp_full_valid", 32'(out_valid), 32'h1);
    check("bp_full_id", 32'(out_unit_id), 32'h5);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_rd_en", 32'(unit_in_rd_en), 32'h00);
      check("bp_hold_id", 32'(out_unit_id), 32'h5);
      check("bp_hold_data", 32'(out), 32'hC0C5);
    end
    out_rd_en = 1'b1;
    #1;
    check("bp_release_grant", 32'(unit_in_rd_en), 32'h80);
    step();
    check("bp_out6", 32'(out_unit_id), 32'h6);
    check("bp_g0", 32'(unit_in_rd_en), 32'h01);
    step();
    check("bp_out7", 32'(out_unit_id), 32'h7);
    out_rd_en = 1'b0;
    #1;
    check("bp_refull_rd_en", 32'(unit_in_rd_en), 32'h00);
    check("bp_refull_valid", 32'(out_valid), 32'h1);

    // reset with a full pipe
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_rd_en", 32'(unit_in_rd_en), 32'h0);
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_id", 32'(out_unit_id), 32'h0);
    step();
    check("midrst_rd_en_hold", 32'(unit_in_rd_en), 32'h0);
    check("midrst_valid_hold", 32'(out_valid), 32'h0);

    // all units valid after release: unit 0 first, then full-rate rotation
    reset = 1'b0;
    out_rd_en = 1'b1;
    #1;
    check("rr_first_grant", 32'(unit_in_rd_en), 32'h01);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("rr_rd_en", 32'(unit_in_rd_en), 32'(8'h01 << (k % 8)));
      if (k >= 2) begin
        check("rr_valid", 32'(out_valid), 32'h1);
        check("rr_id", 32'(out_unit_id), 32'((k - 2) % 8));
        check("rr_data", 32'(out), 32'h0000C0C0 + 32'((k - 2) % 8));
      end else begin
        check("rr_latency", 32'(out_valid), 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
